// File: rtl/bus_seq_pkg.sv
// Shared types and helpers for the bus transfer sequencer.
// Imported by the arbiter, the sequencer top and the bench.
package bus_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int N_REQ_DEF  = 4;
    localparam int N_DEST_DEF = 4;
    localparam int DATA_W_DEF = 16;
    localparam int LEN_W_DEF  = 4;

    // One spare code beyond N_DEST-1 so a master can name a missing register
    function automatic int dest_w(input int n_dest);
        return $clog2(n_dest + 1);
    endfunction

    function automatic logic [31:0] onehot_dec(input int idx, input int n);
        logic [31:0] r;
        r = '0;
        if (idx >= 0 && idx < n)
            r = 32'd1 << idx;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first active request at or after ptr,
// wrapping past the top index.
module rr_arbiter
    import bus_seq_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] win,
    output logic [IDX_W-1:0] win_idx
);

    logic found;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!found && req[i] && i == (int'(ptr) + j) % N_REQ) begin
                    found   = 1'b1;
                    win[i]  = 1'b1;
                    win_idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Round-robin arbiter and burst sequencer for the shared multidrop data bus.
// One owner per burst, one beat per cycle, one idle cycle between owners.
module bus_transfer_sequencer
    import bus_seq_pkg::*;
#(
    parameter  int N_REQ  = N_REQ_DEF,
    parameter  int N_DEST = N_DEST_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int LEN_W  = LEN_W_DEF,
    localparam int DEST_W = dest_w(N_DEST),
    localparam int IDX_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DEST_W-1:0] req_dest,
    input  logic [N_REQ*LEN_W-1:0]  req_len,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        ack,
    output logic [N_REQ-1:0]        done,
    output logic [DATA_W-1:0]       data_bus,
    output logic [N_DEST-1:0]       dest_en,
    output logic                    busy
);

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q;
    logic [IDX_W-1:0]   gidx_q;
    logic [DEST_W-1:0]  dest_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   ptr_q;

    logic [N_REQ-1:0]   win;
    logic [IDX_W-1:0]   win_idx;
    logic               live;
    logic               last;
    logic [DATA_W-1:0]  owner_data;
    logic [N_DEST-1:0]  dest_dec;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .win     (win),
        .win_idx (win_idx)
    );

    assign live       = |(req & grant_q);
    assign last       = (cnt_q == '0);
    assign owner_data = req_data[gidx_q*DATA_W +: DATA_W];

    // Out-of-range destinations decode to no enable at all
    always_comb begin
        dest_dec = '0;
        for (int i = 0; i < N_DEST; i++)
            dest_dec[i] = (int'(dest_q) == i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            dest_q  <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && |req) begin
                grant_q <= win;
                gidx_q  <= win_idx;
                dest_q  <= req_dest[win_idx*DEST_W +: DEST_W];
                cnt_q   <= req_len[win_idx*LEN_W +: LEN_W];
                ptr_q   <= (win_idx == IDX_W'(N_REQ - 1)) ? '0
                                                         : win_idx + IDX_W'(1);
            end else if (state_q == XFER && live && !last) begin
                cnt_q <= cnt_q - LEN_W'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant    = '0;
        ack      = '0;
        done     = '0;
        data_bus = '0;
        dest_en  = '0;
        busy     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req)
                    state_d = XFER;
            end
            XFER: begin
                busy  = 1'b1;
                grant = grant_q;
                if (live) begin
                    ack      = grant_q;
                    data_bus = owner_data;
                    dest_en  = dest_dec;
                    if (last) begin
                        done    = grant_q;
                        state_d = GAP;
                    end
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Directed bench for bus_transfer_sequencer: per-cycle vector tables
// plus hand-written reset and abort sequences.
module tb_bus_transfer_sequencer;
    import bus_seq_pkg::*;

    localparam int NR  = 4;
    localparam int ND  = 4;
    localparam int DW  = 16;
    localparam int LW  = 4;
    localparam int DSW = dest_w(ND);

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*DSW-1:0] req_dest;
    logic [NR*LW-1:0]  req_len;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     grant, ack, done;
    logic [DW-1:0]     data_bus;
    logic [ND-1:0]     dest_en;
    logic              busy;

    int passed = 0;
    int total  = 0;

    logic [DW-1:0] bank [ND];

    typedef struct {
        logic [NR-1:0]     req;
        logic [NR*DSW-1:0] dst;
        logic [NR*LW-1:0]  len;
        logic [NR*DW-1:0]  dat;
        logic [NR-1:0]     grant;
        logic [NR-1:0]     ack;
        logic [NR-1:0]     done;
        logic [ND-1:0]     den;
        logic [DW-1:0]     bus;
        logic              busy;
    } vec_t;

    vec_t seg1[$];
    vec_t seg2[$];

    bus_transfer_sequencer #(
        .N_REQ(NR), .N_DEST(ND), .DATA_W(DW), .LEN_W(LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_dest (req_dest),
        .req_len  (req_len),
        .req_data (req_data),
        .grant    (grant),
        .ack      (ack),
        .done     (done),
        .data_bus (data_bus),
        .dest_en  (dest_en),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Destination register bank A..D fed by the bus
    initial for (int i = 0; i < ND; i++) bank[i] = '0;
    always @(posedge clk)
        for (int i = 0; i < ND; i++)
            if (dest_en[i]) bank[i] <= data_bus;

    function automatic logic [NR*DSW-1:0] pk(input int d3, d2, d1, d0);
        return {DSW'(d3), DSW'(d2), DSW'(d1), DSW'(d0)};
    endfunction

    function automatic vec_t mk(
        input logic [NR-1:0] r, input logic [NR*DSW-1:0] d,
        input logic [NR*LW-1:0] l, input logic [NR*DW-1:0] x,
        input logic [NR-1:0] g, input logic [NR-1:0] a,
        input logic [NR-1:0] dn, input logic [ND-1:0] de,
        input logic [DW-1:0] b, input logic bz);
        vec_t v;
        v.req = r; v.dst = d; v.len = l; v.dat = x;
        v.grant = g; v.ack = a; v.done = dn;
        v.den = de; v.bus = b; v.busy = bz;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, ".grant"}, 32'(grant), 32'(v.grant));
        chk({tag, ".ack"}, 32'(ack), 32'(v.ack));
        chk({tag, ".done"}, 32'(done), 32'(v.done));
        chk({tag, ".dest_en"}, 32'(dest_en), 32'(v.den));
        chk({tag, ".data_bus"}, 32'(data_bus), 32'(v.bus));
        chk({tag, ".busy"}, 32'(busy), 32'(v.busy));
    endtask

    task automatic apply(input string tag, input vec_t v);
        @(negedge clk);
        req = v.req; req_dest = v.dst; req_len = v.len; req_data = v.dat;
        #1;
        check_outs(tag, v);
    endtask

    vec_t zero_v;

    initial begin
        logic [NR*DW-1:0] d4;
        zero_v = mk('0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0);

        // Single beat to B, then a 4-beat burst to D
        seg1.push_back(mk(4'b0001, pk(0,0,0,1), 16'h0000, 64'h0008,
                          0, 0, 0, 0, 16'h0000, 0));
        seg1.push_back(mk(4'b0001, pk(0,0,0,1), 16'h0000, 64'h0008,
                          4'b0001, 4'b0001, 4'b0001, 4'b0010, 16'h0008, 1));
        seg1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        seg1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        seg1.push_back(mk(4'b0010, pk(0,0,3,0), 16'h0030, 64'h0011_0000,
                          0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++)
            seg1.push_back(mk(4'b0010, pk(0,0,3,0), 16'h0030,
                              64'(16'h0011 + k) << 16,
                              4'b0010, 4'b0010, (k == 3) ? 4'b0010 : 4'b0000,
                              4'b1000, 16'h0011 + 16'(k), 1));
        seg1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        seg1.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // All four requesting: grants rotate 0,1,2,3,0 with a gap each time
        d4 = 64'h00A3_00A2_00A1_00A0;
        for (int k = 0; k < 5; k++) begin
            int o;
            o = k % 4;
            seg2.push_back(mk(4'b1111, pk(3,2,1,0), 16'h0000, d4,
                              0, 0, 0, 0, 0, 0));
            seg2.push_back(mk(4'b1111, pk(3,2,1,0), 16'h0000, d4,
                              4'(1 << o), 4'(1 << o), 4'(1 << o), 4'(1 << o),
                              16'h00A0 + 16'(o), 1));
            seg2.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        end
        seg2.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // Destination 5 does not exist: acks and done, but no enable
        seg2.push_back(mk(4'b0001, pk(0,0,0,5), 16'h0001, 64'h0055,
                          0, 0, 0, 0, 0, 0));
        seg2.push_back(mk(4'b0001, pk(0,0,0,5), 16'h0001, 64'h0055,
                          4'b0001, 4'b0001, 0, 0, 16'h0055, 1));
        seg2.push_back(mk(4'b0001, pk(0,0,0,5), 16'h0001, 64'h0055,
                          4'b0001, 4'b0001, 4'b0001, 0, 16'h0055, 1));
        seg2.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        seg2.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        rst = 1'b1; req = '0; req_dest = '0; req_len = '0; req_data = '0;
        @(negedge clk);
        @(negedge clk);
        #1 check_outs("reset_held", zero_v);
        rst = 1'b0;
        #1 check_outs("reset_rel", zero_v);

        foreach (seg1[i]) apply($sformatf("seg1[%0d]", i), seg1[i]);
        chk("bank_B", 32'(bank[1]), 32'h0008);
        chk("bank_D", 32'(bank[3]), 32'h0014);

        // Reset mid-burst clears outputs before the next edge
        apply("mid_arb", mk(4'b0010, pk(0,0,2,0), 16'h0030, 64'h0077_0000,
                            0, 0, 0, 0, 0, 0));
        @(negedge clk);
        #1 chk("mid_xfer.dest_en", 32'(dest_en), 32'h4);
        rst = 1'b1;
        #1 check_outs("mid_rst", zero_v);
        @(negedge clk);
        rst = 1'b0; req = '0; req_dest = '0; req_len = '0; req_data = '0;
        #1 check_outs("mid_rst_rel", zero_v);

        foreach (seg2[i]) apply($sformatf("seg2[%0d]", i), seg2[i]);
        chk("bank_A", 32'(bank[0]), 32'h00A0);
        chk("bank_B2", 32'(bank[1]), 32'h00A1);
        chk("bank_C", 32'(bank[2]), 32'h00A2);
        chk("bank_D2", 32'(bank[3]), 32'h00A3);

        // Requester 2 aborts after two beats; 3 and 0 wait, 3 wins by rotation
        apply("abt0", mk(4'b0100, pk(0,2,0,0), 16'h0700, 64'h0033_0021_0000_0000,
                         0, 0, 0, 0, 0, 0));
        apply("abt1", mk(4'b1101, pk(0,2,0,0), 16'h0700, 64'h0033_0021_0000_0000,
                         4'b0100, 4'b0100, 0, 4'b0100, 16'h0021, 1));
        apply("abt2", mk(4'b1101, pk(0,2,0,0), 16'h0700, 64'h0033_0022_0000_0000,
                         4'b0100, 4'b0100, 0, 4'b0100, 16'h0022, 1));
        apply("abt3", mk(4'b1001, pk(0,2,0,0), 16'h0700, 64'h0033_0023_0000_0000,
                         4'b0100, 0, 0, 0, 0, 1));
        apply("abt4", mk(4'b1001, pk(0,2,0,0), 16'h0700, 64'h0033_0000_0000_0000,
                         0, 0, 0, 0, 0, 1));
        apply("abt5", mk(4'b1001, pk(0,2,0,0), 16'h0700, 64'h0033_0000_0000_0000,
                         0, 0, 0, 0, 0, 0));
        apply("abt6", mk(4'b1001, pk(0,2,0,0), 16'h0700, 64'h0033_0000_0000_0000,
                         4'b1000, 4'b1000, 4'b1000, 4'b0001, 16'h0033, 1));
        apply("abt7", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        apply("abt8", zero_v);
        chk("bank_A_abort", 32'(bank[0]), 32'h0033);
        chk("bank_C_abort", 32'(bank[2]), 32'h0022);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
